// File: rtl/apb_reg_slave_if.sv
// APB bus bundle between the bridge (master) and one register slave.
// dbg_state mirrors the slave FSM state so checkers can bind to it.
interface apb_reg_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  dbg_state;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR, dbg_state
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR, dbg_state
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB register-bank slave with programmable wait states and address/ID decode.
// Handshake: a transfer completes only in the single cycle PREADY=1; PRDATA/PSLVERR are meaningful only then.
module apb_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          ADDR_BITS   = 6,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input logic             HCLK,
    input logic             HRESETn,
    apb_reg_slave_if.slave  apb
);
    localparam int IW = ADDR_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [2**IW-1:0] f_valid_mask();
        logic [2**IW-1:0] v;
        for (int i = 0; i < 2**IW; i++) v[i] = (i < NUM_REGS);
        return v;
    endfunction

    localparam logic [2**IW-1:0] IDX_VALID = f_valid_mask();

    function automatic logic f_err(input logic [31:0] addr, input logic wr);
        logic [IW-1:0] idx;
        idx = addr[ADDR_BITS-1:2];
        return (addr[1:0] != 2'b00) ||
               (addr[31:ADDR_BITS] != BASE_ADDR[31:ADDR_BITS]) ||
               !IDX_VALID[idx] ||
               (wr && (idx == '0));
    endfunction

    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [31:0]   r_addr, r_wdata;
    logic          r_write;
    logic [31:0]   r_regs [NUM_REGS];
    logic [31:0]   r_prdata;
    logic          r_pready, r_pslverr;

    logic          w_capture, w_write, w_err, w_commit;
    logic [31:0]   w_addr, w_rd_val;
    logic [IW-1:0] w_idx, w_cur_idx;

    // A setup phase is accepted from IDLE or overlapped with the DONE cycle.
    assign w_capture = apb.PSEL && !apb.PENABLE && (r_state == S_IDLE || r_state == S_DONE);
    assign w_addr    = w_capture ? apb.PADDR  : r_addr;
    assign w_write   = w_capture ? apb.PWRITE : r_write;
    assign w_idx     = w_addr[ADDR_BITS-1:2];
    assign w_cur_idx = r_addr[ADDR_BITS-1:2];
    assign w_err     = f_err(w_addr, w_write);
    assign w_commit  = (r_state == S_DONE) && apb.PSEL && r_write && !f_err(r_addr, r_write);

    always_comb begin
        w_rd_val = r_regs[w_idx];
        if (w_idx == '0)
            w_rd_val = ID_VALUE;
        else if (w_commit && (w_cur_idx == w_idx))
            w_rd_val = r_wdata;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_next     = S_IDLE;
                w_cnt_next = 4'd0;
                if (w_capture) begin
                    w_next     = (WAIT_STATES == 0) ? S_DONE : S_SETUP;
                    w_cnt_next = 4'(WAIT_STATES);
                end
            end
            S_SETUP, S_WAIT: begin
                if (apb.PSEL && apb.PENABLE) begin
                    if (r_cnt <= 4'd1) begin
                        w_next     = S_DONE;
                        w_cnt_next = 4'd0;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end else begin
                    w_next     = S_IDLE;
                    w_cnt_next = 4'd0;
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so PREADY lands in the right access cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_write   <= 1'b0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            if (w_capture) begin
                r_addr  <= apb.PADDR;
                r_write <= apb.PWRITE;
                r_wdata <= apb.PWDATA;
            end
            if (w_commit) r_regs[w_cur_idx] <= r_wdata;
            r_pready  <= (w_next == S_DONE);
            r_pslverr <= (w_next == S_DONE) && w_err;
            r_prdata  <= ((w_next == S_DONE) && !w_err && !w_write) ? w_rd_val : 32'd0;
        end
    end

    assign apb.PRDATA    = r_prdata;
    assign apb.PREADY    = r_pready;
    assign apb.PSLVERR   = r_pslverr;
    assign apb.dbg_state = r_state;
endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with 1 wait state, one with none.
module tb_apb_reg_slave;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        err;
    int          lows;

    apb_reg_slave_if bus ();
    apb_reg_slave_if bus0 ();

    apb_reg_slave #(.WAIT_STATES(1)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .apb(bus));
    apb_reg_slave #(.WAIT_STATES(0)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .apb(bus0));

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        bus.PSEL = sel; bus.PENABLE = en; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = d;
    endtask

    task automatic drv0(input logic sel, input logic en, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        @(posedge HCLK); #1;
        bus0.PSEL = sel; bus0.PENABLE = en; bus0.PWRITE = wr; bus0.PADDR = a; bus0.PWDATA = d;
    endtask

    // Full transfer; address/data/direction are scrambled during the access phase on purpose.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic slverr, output int nlow);
        drv(1'b1, 1'b0, wr, addr, wd);
        @(posedge HCLK); #1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = addr ^ 32'h0000_0008;
        bus.PWDATA  = ~wd;
        bus.PWRITE  = ~wr;
        nlow = 0;
        @(negedge HCLK);
        while (!bus.PREADY && nlow < 20) begin
            nlow++;
            @(negedge HCLK);
        end
        rdata  = bus.PRDATA;
        slverr = bus.PSLVERR;
        drv(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
        bus0.PSEL = 0; bus0.PENABLE = 0; bus0.PWRITE = 0; bus0.PADDR = 0; bus0.PWDATA = 0;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_pready", bus.PREADY, 0);
        chk("rst_pslverr", bus.PSLVERR, 0);
        chk("rst_prdata", bus.PRDATA, 0);
        chk("rst_state", bus.dbg_state, 0);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        xfer(1, 32'h8000_0004, 32'hDEAD_BEEF, rd, err, lows);
        chk("wr_r1_lows", lows, 1);
        chk("wr_r1_err", err, 0);
        xfer(0, 32'h8000_0004, 32'd0, rd, err, lows);
        chk("rd_r1_lows", lows, 1);
        chk("rd_r1_data", rd, 32'hDEAD_BEEF);
        chk("rd_r1_err", err, 0);

        xfer(0, 32'h8000_0000, 32'd0, rd, err, lows);
        chk("rd_id_data", rd, 32'hA9B0_0001);
        chk("rd_id_err", err, 0);
        xfer(1, 32'h8000_0000, 32'h1234_5678, rd, err, lows);
        chk("wr_id_err", err, 1);
        chk("wr_id_data", rd, 0);
        xfer(0, 32'h8000_0000, 32'd0, rd, err, lows);
        chk("rerd_id_data", rd, 32'hA9B0_0001);

        xfer(1, 32'h8000_0008, 32'h55AA_1234, rd, err, lows);
        chk("wr_r2_err", err, 0);
        xfer(0, 32'h8000_0040, 32'd0, rd, err, lows);
        chk("oor_err", err, 1);
        chk("oor_data", rd, 0);
        xfer(0, 32'h9000_0004, 32'd0, rd, err, lows);
        chk("base_err", err, 1);
        chk("base_data", rd, 0);
        xfer(1, 32'h8000_0006, 32'hFFFF_0000, rd, err, lows);
        chk("misal_err", err, 1);
        chk("misal_data", rd, 0);
        xfer(0, 32'h8000_0008, 32'd0, rd, err, lows);
        chk("r2_kept", rd, 32'h55AA_1234);
        xfer(0, 32'h8000_0004, 32'd0, rd, err, lows);
        chk("r1_kept", rd, 32'hDEAD_BEEF);

        // Back-to-back writes: next setup overlaps the DONE cycle.
        drv(1, 0, 1, 32'h8000_000C, 32'd1);
        drv(1, 1, 1, 32'h8000_000C, 32'd1);
        @(negedge HCLK); chk("b2b_a_wait", bus.PREADY, 0);
        drv(1, 0, 1, 32'h8000_0010, 32'd2);
        @(negedge HCLK); chk("b2b_a_done", bus.PREADY, 1);
        drv(1, 1, 1, 32'h8000_0010, 32'd2);
        @(negedge HCLK); chk("b2b_b_wait", bus.PREADY, 0);
        drv(1, 0, 1, 32'h8000_0014, 32'd3);
        @(negedge HCLK); chk("b2b_b_done", bus.PREADY, 1);
        drv(1, 1, 1, 32'h8000_0014, 32'd3);
        @(negedge HCLK); chk("b2b_c_wait", bus.PREADY, 0);
        drv(1, 1, 1, 32'h8000_0014, 32'd3);
        @(negedge HCLK); chk("b2b_c_done", bus.PREADY, 1);
        drv(0, 0, 0, 32'd0, 32'd0);
        xfer(0, 32'h8000_000C, 32'd0, rd, err, lows);
        chk("b2b_r3", rd, 1);
        xfer(0, 32'h8000_0010, 32'd0, rd, err, lows);
        chk("b2b_r4", rd, 2);
        xfer(0, 32'h8000_0014, 32'd0, rd, err, lows);
        chk("b2b_r5", rd, 3);

        // Abort: PSEL dropped where the access phase should have started.
        drv(1, 0, 1, 32'h8000_0018, 32'hFFFF_FFFF);
        @(negedge HCLK); chk("abort_setup_rdy", bus.PREADY, 0);
        drv(0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK); chk("abort_wait_rdy", bus.PREADY, 0);
        drv(0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK); chk("abort_late_rdy", bus.PREADY, 0);
        xfer(0, 32'h8000_0018, 32'd0, rd, err, lows);
        chk("abort_r6", rd, 0);

        // Stray access phase with no setup.
        drv(1, 1, 1, 32'h8000_0004, 32'h0BAD_0BAD);
        @(negedge HCLK); chk("stray_rdy0", bus.PREADY, 0);
        drv(1, 1, 1, 32'h8000_0004, 32'h0BAD_0BAD);
        @(negedge HCLK); chk("stray_rdy1", bus.PREADY, 0);
        chk("stray_state", bus.dbg_state, 0);
        drv(0, 0, 0, 32'd0, 32'd0);
        xfer(0, 32'h8000_0004, 32'd0, rd, err, lows);
        chk("stray_r1", rd, 32'hDEAD_BEEF);

        // Reset in the wait cycle of a write to reg 7.
        drv(1, 0, 1, 32'h8000_001C, 32'h7777_7777);
        drv(1, 1, 1, 32'h8000_001C, 32'h7777_7777);
        #2; HRESETn = 1'b0;
        #1;
        chk("rstw_pready", bus.PREADY, 0);
        chk("rstw_pslverr", bus.PSLVERR, 0);
        chk("rstw_state", bus.dbg_state, 0);
        bus.PSEL = 0; bus.PENABLE = 0;
        @(posedge HCLK); #1; HRESETn = 1'b1;

        // Reset in the DONE cycle: PREADY must fall before any clock edge.
        drv(1, 0, 1, 32'h8000_001C, 32'h7777_7777);
        drv(1, 1, 1, 32'h8000_001C, 32'h7777_7777);
        drv(1, 1, 1, 32'h8000_001C, 32'h7777_7777);
        chk("rstd_pre_rdy", bus.PREADY, 1);
        #2; HRESETn = 1'b0;
        #1;
        chk("rstd_pready", bus.PREADY, 0);
        bus.PSEL = 0; bus.PENABLE = 0;
        @(posedge HCLK); #1; HRESETn = 1'b1;
        xfer(0, 32'h8000_001C, 32'd0, rd, err, lows);
        chk("rst_r7", rd, 0);
        xfer(0, 32'h8000_0004, 32'd0, rd, err, lows);
        chk("rst_r1", rd, 0);

        // Zero wait states: PREADY on the first access cycle.
        drv0(1, 0, 1, 32'h8000_0008, 32'hCAFE_0000);
        @(negedge HCLK); chk("ws0_setup_rdy", bus0.PREADY, 0);
        drv0(1, 1, 1, 32'h8000_0008, 32'hCAFE_0000);
        @(negedge HCLK);
        chk("ws0_wr_rdy", bus0.PREADY, 1);
        chk("ws0_wr_err", bus0.PSLVERR, 0);
        drv0(1, 0, 0, 32'h8000_0008, 32'd0);
        @(negedge HCLK); chk("ws0_gap_rdy", bus0.PREADY, 0);
        drv0(1, 1, 0, 32'h8000_0008, 32'd0);
        @(negedge HCLK);
        chk("ws0_rd_rdy", bus0.PREADY, 1);
        chk("ws0_rd_data", bus0.PRDATA, 32'hCAFE_0000);
        drv0(0, 0, 0, 32'd0, 32'd0);
        @(negedge HCLK); chk("ws0_idle_rdy", bus0.PREADY, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
